pc_redirect_unit: RTL
=====================

Name: pc_redirect_unit

Overview:
Program-counter sequencer for the MIPS pipeline; consumes the branch-taken decision (Branch AND Zero) and jump requests from EX and owns the fetch PC.
- Inserts a fixed number of flush bubbles after every accepted redirect.
- Honours pipeline stalls.
- Flags misaligned targets.
- Sits between the EX-stage branch logic and instruction memory / IF/ID register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FLUSH_CYCLES, 1, bubble cycles after a redirect; legal range 1..3.

Ports:
Clk  input  1  rising-edge clock.
Rst  input  1  reset; synchronous, active-low.
Stall  input  1  hazard-unit stall request; hold PC.
BranchTaken  input  1  branch decision from EX (Branch AND Zero).
BranchTarget  input  32  branch target address.
Jump  input  1  jump request from EX.
JumpTarget  input  32  jump target address.
PC  output  32  current fetch address, registered.
PCPlus4  output  32  PC + 4, combinational from PC, modulo 2^32.
FlushIFID  output  1  clear IF/ID register, registered.
FlushIDEX  output  1  clear ID/EX register, registered.
Misaligned  output  1  one-cycle pulse: accepted target had bits [1:0] != 0.
RedirectCount  output  16  accepted-redirect count (see Optional Feature).

Behaviour:
Clocking and reset:
- Single clock domain; all state updates on rising Clk.
- Rst low at an edge: PC=RESET_PC, state=RUN, bubble counter=0, FlushIFID=0, FlushIDEX=0, Misaligned=0, RedirectCount=0.
- Reset overrides everything, including mid-FLUSH.

State RUN:
- Redirect request present = BranchTaken or Jump.
- Priority: BranchTaken > Jump > Stall > increment.
- Redirect accepted at edge:
  - PC <= target with bits [1:0] forced to 0.
  - Misaligned <= (target[1:0] != 0).
  - state <= FLUSH; bubble counter <= FLUSH_CYCLES-1.
  - FlushIFID <= 1; FlushIDEX <= 1.
- Redirect wins over a simultaneous Stall.
- No redirect, Stall=1: PC held; flushes <= 0; Misaligned <= 0.
- No redirect, Stall=0: PC <= PC+4; flushes <= 0; Misaligned <= 0.
- PC+4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.

State FLUSH:
- PC held at the redirect target.
- BranchTaken, Jump and Stall ignored; requests raised during FLUSH are dropped, not queued.
- Misaligned <= 0 (single pulse).
- Counter != 0: counter decrements; FlushIFID and FlushIDEX stay 1.
- Counter == 0: state <= RUN; FlushIFID <= 0; FlushIDEX <= 0.

Timing:
- Flush outputs are high for exactly FLUSH_CYCLES cycles, starting the cycle after acceptance.
- The first RUN cycle after FLUSH treats PC as a normal fetch; the next non-stalled edge gives target+4.
- Latency request -> PC update: 1 edge.
- No combinational path from any input to any output except PC -> PCPlus4.

Optional Feature:
Macro: PC_REDIRECT_COUNT_EN.
- Defined: RedirectCount increments by 1 on every accepted redirect (branch or jump); saturates at 16'hFFFF; cleared only by reset.
- Not defined: no counter register; RedirectCount is tied to 16'h0000. The port is present in both builds.

Test Plan:
1. Reset with RESET_PC=32'h0040_0000, then Stall=0 for 3 edges -> PC = 0x00400000, 0x00400004, 0x00400008, 0x0040000C; flushes 0.
2. BranchTaken=1, BranchTarget=0x00400100, with Jump=1, JumpTarget=0x00400200 and Stall=1 in the same cycle (FLUSH_CYCLES=1) -> next PC=0x00400100; FlushIFID/FlushIDEX high 1 cycle; then PC=0x00400104 on the following non-stalled edge.
3. FLUSH_CYCLES=3; Jump to 0x00001000 followed by BranchTaken pulse during FLUSH -> PC holds 0x00001000 for 3 cycles; flushes high 3 cycles; branch ignored; PC=0x00001004 after.
4. BranchTarget=0x00400103 taken -> PC=0x00400100; Misaligned high exactly 1 cycle.
5. PC=0xFFFFFFFC (via jump), run unstalled -> PC=0x00000000 next; Rst low during a FLUSH_CYCLES=3 flush -> PC=RESET_PC, flushes 0 at that edge.
6. With PC_REDIRECT_COUNT_EN: 3 accepted redirects -> RedirectCount=3; a redirect dropped in FLUSH is not counted. Without the macro: RedirectCount stays 0.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the fetch PC, applies branch/jump redirects from EX,
// holds the PC for FLUSH_CYCLES bubble cycles after each accepted redirect,
// honours hazard stalls and flags misaligned targets.
// Optional build macro: PC_REDIRECT_COUNT_EN enables the saturating
// accepted-redirect counter on RedirectCount; without it the port reads zero.
// FLUSH_CYCLES must be in the range 1..3 (bubble counter is two bits wide).
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        FlushIFID,
    output logic        FlushIDEX,
    output logic        Misaligned,
    output logic [15:0] RedirectCount
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Counter load value: remaining bubbles after the first flush cycle.
    localparam logic [1:0] BUBBLE_INIT = 2'(FLUSH_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [1:0]  bubble_reg, bubble_next;
    logic [31:0] pc_reg, pc_next;
    logic        flush_reg, flush_next;
    logic        misaligned_reg, misaligned_next;
    logic        redirect_accept;
    logic [31:0] redirect_target;

    // State register: all control state updates on the rising edge, reset wins.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_reg      <= ST_RUN;
            bubble_reg     <= 2'd0;
            pc_reg         <= RESET_PC;
            flush_reg      <= 1'b0;
            misaligned_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bubble_reg     <= bubble_next;
            pc_reg         <= pc_next;
            flush_reg      <= flush_next;
            misaligned_reg <= misaligned_next;
        end
    end

    // Next-state logic: branch beats jump beats stall beats sequential fetch;
    // requests arriving while flushing are dropped.
    always_comb begin
        state_next      = state_reg;
        bubble_next     = bubble_reg;
        pc_next         = pc_reg;
        flush_next      = 1'b0;
        misaligned_next = 1'b0;
        redirect_accept = 1'b0;
        redirect_target = 32'h0000_0000;

        case (state_reg)
            ST_RUN: begin
                if (BranchTaken) begin
                    redirect_accept = 1'b1;
                    redirect_target = BranchTarget;
                end else if (Jump) begin
                    redirect_accept = 1'b1;
                    redirect_target = JumpTarget;
                end

                if (redirect_accept) begin
                    // Low bits are forced to word alignment; the error is reported instead.
                    pc_next         = {redirect_target[31:2], 2'b00};
                    misaligned_next = |redirect_target[1:0];
                    state_next      = ST_FLUSH;
                    bubble_next     = BUBBLE_INIT;
                    flush_next      = 1'b1;
                end else if (!Stall) begin
                    pc_next = pc_reg + 32'd4;
                end
            end

            ST_FLUSH: begin
                if (bubble_reg != 2'd0) begin
                    bubble_next = bubble_reg - 2'd1;
                    flush_next  = 1'b1;
                end else begin
                    state_next = ST_RUN;
                end
            end

            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

`ifdef PC_REDIRECT_COUNT_EN
    logic [15:0] count_reg;

    // Accepted-redirect counter, saturating at all-ones, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            count_reg <= 16'h0000;
        end else if (redirect_accept && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign RedirectCount = count_reg;
`else
    assign RedirectCount = 16'h0000;
`endif

    assign PC         = pc_reg;
    assign PCPlus4    = pc_reg + 32'd4;
    assign FlushIFID  = flush_reg;
    assign FlushIDEX  = flush_reg;
    assign Misaligned = misaligned_reg;

endmodule
